// File: rtl/spi_flash_reader.sv
// -----------------------------------------------------------------------------
// spi_flash_reader
//
// Read sequencer for serial NOR flash. It sits upstream of the `spi` byte
// engine. On a start pulse it lowers chip-select, sends the READ opcode and a
// 24-bit address through the engine's tx_req/data_tx/spi_ready handshake, then
// clocks out dummy bytes and streams the returned bytes on a valid/ready port.
//
// Configuration macro: SPI_FLASH_FAST_READ_EN
//   defined   -> opcode 0x0B, 3 address bytes, 1 dummy byte (5-byte header)
//   undefined -> opcode 0x03, 3 address bytes            (4-byte header)
//
// Parameters
//   CS_SETUP  cycles from cs low to the first tx_req (1..15)
//   CS_HOLD   cycles cs stays low after the last byte, and minimum cs-high
//             time before returning to idle (1..15)
//
// Ports
//   PCLK       clock, rising edge
//   PRESET     asynchronous active-high reset
//   start      one-cycle request, sampled only when idle
//   addr       flash byte address, captured on accepted start
//   len        byte count, captured on accepted start (0 means 256)
//   busy       high from accepted start through the last cs-high hold cycle
//   done       one-cycle pulse as the block returns to idle
//   rd_data    received byte
//   rd_valid   rd_data is valid
//   rd_ready   consumer accepts the byte when rd_valid & rd_ready
//   cs         engine chip-select, active low
//   tx_req     one-cycle byte-start pulse to the engine
//   data_tx    byte to shift out, stable while the engine is busy
//   data_rx    byte shifted in, valid while spi_ready is high after completion
//   spi_ready  engine idle / previous byte complete
// -----------------------------------------------------------------------------
module spi_flash_reader #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [7:0]  len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        cs,
    output logic        tx_req,
    output logic [7:0]  data_tx,
    input  logic [7:0]  data_rx,
    input  logic        spi_ready
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE  = 8'h0B;
    localparam int         HDR_LEN = 5;
`else
    localparam logic [7:0] OPCODE  = 8'h03;
    localparam int         HDR_LEN = 4;
`endif

    localparam logic [2:0] HDR_LAST   = 3'(HDR_LEN - 1);
    localparam logic [4:0] SETUP_LAST = 5'(CS_SETUP - 1);
    localparam logic [4:0] HOLD_MID   = 5'(CS_HOLD - 1);
    localparam logic [4:0] HOLD_LAST  = 5'(2 * CS_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_CMD_WAIT,
        ST_RD,
        ST_RD_WAIT,
        ST_OUT,
        ST_HOLD
    } state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;            // shared cs setup / hold timer
    logic [2:0]  byte_idx, byte_idx_n;  // header byte being sent
    logic [8:0]  len_cnt, len_cnt_n;    // bytes still to deliver, 1..256
    logic [23:0] addr_q, addr_n;
    logic        seen_low, seen_low_n;  // engine has dropped spi_ready for this byte

    logic        cs_n, busy_n, done_n, tx_req_n, rd_valid_n;
    logic [7:0]  data_tx_n, rd_data_n;

    // All outputs are registered so tx_req is a clean one-cycle pulse and cs
    // returns high directly from the asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            byte_idx <= '0;
            len_cnt  <= '0;
            addr_q   <= '0;
            seen_low <= 1'b0;
            cs       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_req   <= 1'b0;
            data_tx  <= 8'h00;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            byte_idx <= byte_idx_n;
            len_cnt  <= len_cnt_n;
            addr_q   <= addr_n;
            seen_low <= seen_low_n;
            cs       <= cs_n;
            busy     <= busy_n;
            done     <= done_n;
            tx_req   <= tx_req_n;
            data_tx  <= data_tx_n;
            rd_data  <= rd_data_n;
            rd_valid <= rd_valid_n;
        end
    end

    always_comb begin
        // NOTE: every next value is defaulted first, so no branch can leave a
        // signal unassigned and infer a latch.
        state_n    = state;
        cnt_n      = cnt;
        byte_idx_n = byte_idx;
        len_cnt_n  = len_cnt;
        addr_n     = addr_q;
        seen_low_n = seen_low;
        cs_n       = cs;
        busy_n     = busy;
        done_n     = 1'b0;
        tx_req_n   = 1'b0;
        data_tx_n  = data_tx;
        rd_data_n  = rd_data;
        rd_valid_n = rd_valid;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_n     = addr;
                    len_cnt_n  = (len == 8'd0) ? 9'd256 : {1'b0, len};
                    byte_idx_n = '0;
                    cnt_n      = '0;
                    cs_n       = 1'b0;
                    busy_n     = 1'b1;
                    state_n    = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_CMD;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end

            ST_CMD: begin
                if (spi_ready) begin
                    tx_req_n   = 1'b1;
                    seen_low_n = 1'b0;
                    case (byte_idx)
                        3'd0:    data_tx_n = OPCODE;
                        3'd1:    data_tx_n = addr_q[23:16];
                        3'd2:    data_tx_n = addr_q[15:8];
                        3'd3:    data_tx_n = addr_q[7:0];
                        default: data_tx_n = 8'h00;  // fast-read dummy byte
                    endcase
                    state_n = ST_CMD_WAIT;
                end
            end

            // A byte is complete only once spi_ready has been seen low and
            // then high again; the cycle carrying tx_req still shows the
            // engine's stale ready.
            ST_CMD_WAIT: begin
                if (!spi_ready) begin
                    seen_low_n = 1'b1;
                end else if (seen_low) begin
                    if (byte_idx == HDR_LAST) begin
                        state_n = ST_RD;
                    end else begin
                        byte_idx_n = byte_idx + 3'd1;
                        state_n    = ST_CMD;
                    end
                end
            end

            ST_RD: begin
                if (spi_ready) begin
                    tx_req_n   = 1'b1;
                    seen_low_n = 1'b0;
                    data_tx_n  = 8'h00;
                    state_n    = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (!spi_ready) begin
                    seen_low_n = 1'b1;
                end else if (seen_low) begin
                    rd_data_n  = data_rx;
                    rd_valid_n = 1'b1;
                    state_n    = ST_OUT;
                end
            end

            ST_OUT: begin
                if (rd_ready) begin
                    rd_valid_n = 1'b0;
                    len_cnt_n  = len_cnt - 9'd1;
                    if (len_cnt == 9'd1) begin
                        cnt_n   = '0;
                        state_n = ST_HOLD;
                    end else begin
                        state_n = ST_RD;
                    end
                end
            end

            // First CS_HOLD cycles keep cs low, the next CS_HOLD cycles hold
            // it high; busy drops together with the done pulse.
            ST_HOLD: begin
                cnt_n = cnt + 5'd1;
                if (cnt == HOLD_MID) begin
                    cs_n = 1'b1;
                end
                if (cnt == HOLD_LAST) begin
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_reader
//
// Self-checking bench for spi_flash_reader. A behavioural byte engine answers
// header bytes with 0xEE and the k-th read byte of a transaction with 0xA0+k.
// A table of transactions is run through one task that records the bytes sent,
// the bytes delivered and the cs/busy/done timing, then compares against
// expectations built from the table entry. Hand-written sequences cover the
// reset values and a reset asserted while a read byte is in flight.
// -----------------------------------------------------------------------------
module tb_spi_flash_reader;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int ENG_CYC  = 4;
    localparam int BUDGET   = 4000;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         HDR = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif

    logic        PCLK;
    logic        PRESET;
    logic        start;
    logic [23:0] addr;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        cs;
    logic        tx_req;
    logic [7:0]  data_tx;
    logic [7:0]  data_rx;
    logic        spi_ready;

    int checks   = 0;
    int failures = 0;

    spi_flash_reader #(
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .start     (start),
        .addr      (addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .cs        (cs),
        .tx_req    (tx_req),
        .data_tx   (data_tx),
        .data_rx   (data_rx),
        .spi_ready (spi_ready)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- behavioural spi byte engine ----------------
    logic [7:0] tx_log[$];
    int         tx_idx;
    int         eng_cnt;
    logic [7:0] pend_rx;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            spi_ready <= 1'b1;
            eng_cnt   <= 0;
            data_rx   <= 8'h00;
            pend_rx   <= 8'h00;
            tx_idx    <= 0;
        end else begin
            if (cs) begin
                tx_idx <= 0;
            end
            if (eng_cnt != 0) begin
                if (eng_cnt == 1) begin
                    spi_ready <= 1'b1;
                    data_rx   <= pend_rx;
                end
                eng_cnt <= eng_cnt - 1;
            end else if (tx_req && spi_ready && !cs) begin
                spi_ready <= 1'b0;
                eng_cnt   <= ENG_CYC;
                tx_log.push_back(data_tx);
                pend_rx   <= (tx_idx >= HDR) ? 8'hA0 + 8'(tx_idx - HDR) : 8'hEE;
                tx_idx    <= tx_idx + 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  len;
        int          stall_byte;   // index of byte to back-pressure, -1 none
        int          restart_cyc;  // cycle to pulse a stray start, -1 none
        int          exp_nbytes;
        int          exp_ntx;
    } vec_t;

    task automatic run_txn(input vec_t v);
        logic [7:0] rx_q[$];
        logic [7:0] exp_hdr[5];
        logic [7:0] held;
        logic       prev_cs, prev_tx, prev_valid, prev_hs, hs, stalled;
        int cyc, first_tx, done_cnt, done_cyc, hs_cyc, rise_cyc;
        int cs_rise, glitch, viol, stall_left, bad;

        exp_hdr = '{OPC, v.addr[23:16], v.addr[15:8], v.addr[7:0], 8'h00};
        first_tx = -1; done_cnt = 0; done_cyc = -1; hs_cyc = -1; rise_cyc = -1;
        cs_rise = 0; glitch = 0; viol = 0; stall_left = 0; stalled = 1'b0;
        prev_cs = 1'b0; prev_tx = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0;
        held = 8'h00;
        tx_log.delete();

        @(posedge PCLK); #1;
        addr = v.addr; len = v.len; start = 1'b1; rd_ready = 1'b1;
        @(posedge PCLK); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("cs_after_start", {31'd0, cs}, 32'd0);

        cyc = 0;
        while (cyc < BUDGET) begin
            if (tx_req && first_tx < 0) first_tx = cyc;
            if (tx_req && (prev_tx || !spi_ready)) viol++;
            if (prev_valid && !prev_hs && !rd_valid) viol++;
            if (cs && !prev_cs) begin
                cs_rise++;
                rise_cyc = cyc;
            end
            if (cs && (tx_req || rd_valid)) glitch++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) viol++;
            end else if (!busy) begin
                viol++;
            end

            if (stall_left > 0) begin
                if (tx_req || rd_data != held || cs || !rd_valid) viol++;
                stall_left--;
                if (stall_left == 0) rd_ready = 1'b1;
            end else if (!stalled && v.stall_byte >= 0 && rd_valid &&
                         rx_q.size() == v.stall_byte) begin
                stalled    = 1'b1;
                rd_ready   = 1'b0;
                stall_left = 20;
                held       = rd_data;
            end

            hs = rd_valid && rd_ready;
            if (hs) begin
                rx_q.push_back(rd_data);
                hs_cyc = cyc;
            end
            prev_cs = cs; prev_tx = tx_req; prev_valid = rd_valid; prev_hs = hs;

            start = (cyc == v.restart_cyc);
            if (start) begin
                addr = ~v.addr;
                len  = 8'd9;
            end

            if (done_cnt != 0) break;
            @(posedge PCLK); #1;
            cyc++;
        end
        start = 1'b0;

        check("done_count", done_cnt, 1);
        check("first_tx_latency", first_tx, CS_SETUP + 1);
        for (int i = 0; i < HDR; i++) begin
            check($sformatf("hdr_byte%0d", i),
                  (i < tx_log.size()) ? {24'd0, tx_log[i]} : 32'hDEAD,
                  {24'd0, exp_hdr[i]});
        end
        check("tx_req_count", tx_log.size(), v.exp_ntx);
        bad = 0;
        for (int i = HDR; i < tx_log.size(); i++) if (tx_log[i] != 8'h00) bad++;
        check("read_phase_tx_nonzero", bad, 0);
        check("rd_byte_count", rx_q.size(), v.exp_nbytes);
        bad = 0;
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != 8'hA0 + 8'(i)) bad++;
        check("rd_data_sequence_errors", bad, 0);
        check("cs_rise_count", cs_rise, 1);
        check("cs_high_mid_txn", glitch, 0);
        check("protocol_violations", viol, 0);
        check("cs_hold_low_cycles", rise_cyc - hs_cyc, CS_HOLD + 1);
        check("done_after_last_byte", done_cyc - hs_cyc, 2 * CS_HOLD + 1);
        @(posedge PCLK); #1;
        check("idle_cs", {31'd0, cs}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done_cleared", {31'd0, done}, 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int k;

        vecs[0] = '{24'h012345, 8'd4, -1, -1,   4, HDR + 4};    // basic read
        vecs[1] = '{24'h0ABCDE, 8'd3,  1, -1,   3, HDR + 3};    // back-pressure on byte 2
        vecs[2] = '{24'hFFFFFF, 8'd1, -1, -1,   1, HDR + 1};    // single byte, top address
        vecs[3] = '{24'h000100, 8'd0, -1, -1, 256, HDR + 256};  // len 0 means 256
        vecs[4] = '{24'h5A5A5A, 8'd4, -1, 45,   4, HDR + 4};    // stray start mid-read

        PRESET = 1'b1; start = 1'b0; addr = '0; len = '0; rd_ready = 1'b1;
        #12;
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_tx_req", {31'd0, tx_req}, 32'd0);
        check("rst_data_tx", {24'd0, data_tx}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        repeat (3) @(posedge PCLK);

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i]);
        end

        // Reset while the second read byte is in flight (RD_WAIT).
        tx_log.delete();
        @(posedge PCLK); #1;
        addr = 24'h13579B; len = 8'd4; start = 1'b1; rd_ready = 1'b1;
        @(posedge PCLK); #1;
        start = 1'b0;
        k = 0;
        while (k < 500 && !(tx_log.size() >= HDR + 2 && !spi_ready)) begin
            @(posedge PCLK); #1;
            k++;
        end
        check("reached_rd_wait", {31'd0, k < 500}, 32'd1);
        check("pre_reset_cs_low", {31'd0, cs}, 32'd0);
        check("pre_reset_rd_data", {24'd0, rd_data}, 32'hA0);
        #2 PRESET = 1'b1;
        #1;
        check("midrst_cs", {31'd0, cs}, 32'd1);
        check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_tx_req", {31'd0, tx_req}, 32'd0);
        check("midrst_rd_data", {24'd0, rd_data}, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        repeat (2) @(posedge PCLK);
        run_txn('{24'h0C0FFE, 8'd2, -1, -1, 2, HDR + 2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Hardware read sequencer for serial NOR flash, sitting directly upstream of the `spi` byte engine in the SPI peripheral subsystem. On a start pulse it drives chip-select and issues the READ opcode, a 24-bit address and dummy/read bytes through the engine's `tx_req`/`data_tx`/`spi_ready` handshake. It streams the returned bytes out on a valid/ready port, so sprite and map data load from flash without CPU byte-banging.

## Interface
- `CS_SETUP`, default 2: PCLK cycles from `cs` low to the first `tx_req`; legal range 1..15.
- `CS_HOLD`, default 2: PCLK cycles from the last byte completing to `cs` high, and the minimum `cs`-high time before the next transaction; legal range 1..15.
- `PCLK` input 1: sole clock, rising edge.
- `PRESET` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `addr` input 24: flash byte address, captured on accepted `start`.
- `len` input 8: byte count, captured on accepted `start`; 0 means 256.
- `busy` output 1: high from accepted `start` through the last cycle of CS_HOLD.
- `done` output 1: one-cycle pulse on the CS_HOLD→IDLE transition.
- `rd_data` output 8: received byte.
- `rd_valid` output 1: `rd_data` is valid.
- `rd_ready` input 1: consumer accepts the byte when `rd_valid & rd_ready`.
- `cs` output 1: to the `spi` engine `cs` input; active low.
- `tx_req` output 1: one-cycle byte-start pulse to the engine.
- `data_tx` output 8: byte to shift out; held stable while the engine is busy.
- `data_rx` input 8: byte shifted in; valid while `spi_ready` is high after completion.
- `spi_ready` input 1: engine idle / previous byte complete.

## Operation
- **Engine contract:** the engine starts one byte when `tx_req` is pulsed while `spi_ready`=1. `spi_ready` falls within 2 cycles and rises when the byte completes. The block does not raise a second `tx_req` until `spi_ready` has been seen low and then high.
- **States:** IDLE, SETUP, CMD, CMD_WAIT, RD, RD_WAIT, OUT, HOLD.
  - **IDLE:** `cs`=1. On `start`, capture `addr` and `len` into `len_cnt` (9-bit; 0 maps to 256), set `byte_idx`=0, and go to SETUP.
  - **SETUP:** `cs`=0. Count CS_SETUP cycles, then go to CMD.
  - **CMD:** when `spi_ready`=1, pulse `tx_req` with `data_tx` set per `byte_idx`: 0 → opcode; 1..3 → `addr[23:16]`, `[15:8]`, `[7:0]`. Go to CMD_WAIT.
  - **CMD_WAIT:** wait for completion and discard `data_rx`. If the last header byte is done, go to RD; otherwise increment `byte_idx` and return to CMD.
  - **RD:** when `spi_ready`=1, pulse `tx_req` with `data_tx`=0x00. Go to RD_WAIT.
  - **RD_WAIT:** on completion, latch `data_rx` into `rd_data`, set `rd_valid`, and go to OUT.
  - **OUT:** hold `rd_valid` until `rd_ready`. On handshake, decrement `len_cnt`. If 0, go to HOLD; otherwise go to RD. `cs` stays low while stalled.
  - **HOLD:** `cs`=0 for CS_HOLD cycles, then `cs`=1 for CS_HOLD cycles, then pulse `done` and go to IDLE.
- `start` while `busy` is ignored; no queueing.
- The address is not incremented internally; the flash auto-increments. A read past 0xFFFFFF wraps per flash behaviour, and the block does nothing special.
- `rd_ready` held high gives a throughput of one byte per engine byte time plus 2 cycles.

## Timing
- **Reset values:** `cs`=1, `tx_req`=0, `data_tx`=0x00, `rd_data`=0x00, `rd_valid`=0, `busy`=0, `done`=0, state IDLE.
- Reset asserted mid-transaction returns all of the above on the next evaluation, asynchronously, including `cs` going high immediately. A partial byte in the engine is abandoned.
- `start` accepted at edge N gives `busy`=1 and `cs`=0 after edge N. The first `tx_req` is after edge N+CS_SETUP+1 at the earliest.
- `tx_req` is exactly one cycle wide and registered. `data_tx` changes only in the cycle `tx_req` is asserted.
- `rd_valid` rises the cycle after a completion is detected. It falls the cycle after the handshake and never drops without a handshake.
- `done` and `busy` falling occur at the same edge.

## Configuration
- `SPI_FLASH_FAST_READ_EN`:
  - Defined: the opcode is 0x0B, followed by the 3 address bytes and one dummy byte of 0x00, so the header is 5 bytes.
  - Undefined: the opcode is 0x03 and the header is 4 bytes.

## Test plan
- **Basic read:** `start`, `addr`=0x012345, `len`=4, `rd_ready`=1, engine model returns 0xA0..0xA3. Required: `data_tx` sequence 03,01,23,45,00,00,00,00; `rd_data` 0xA0..0xA3 in order; a single `done`; `cs` low throughout the transaction.
- **Back-pressure:** `len`=3 with `rd_ready` low for 20 cycles on byte 2. Required: no `tx_req` while stalled, `rd_data` stable, `cs` stays low, all 3 bytes delivered.
- **len=0:** required: exactly 256 bytes delivered, 260 `tx_req` pulses, one `done`.
- **Start while busy:** a second `start` mid-read is ignored. Required: `tx_req` count unchanged and only one `done`.
- **Reset mid-read:** `PRESET` asserted during RD_WAIT. Required: immediately `cs`=1, `rd_valid`=0, `busy`=0. A subsequent `start` reads correctly from its new `addr`.
- **Macro build:** with `SPI_FLASH_FAST_READ_EN` defined and `len`=1, required header 0B,aa,bb,cc,00, then one read byte.
